// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: states, opcodes, ALU classes, decode record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_ERROR  = 3'd7
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_SUBIU = 6'b001101;
  localparam logic [5:0] OP_SW    = 6'b010000;
  localparam logic [5:0] OP_LW    = 6'b010001;
  localparam logic [5:0] OP_SLTI  = 6'b101010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_SLT   = 2'b11;

  typedef enum logic [1:0] {
    CL_RTYPE,
    CL_IMM_ALU,
    CL_LOAD,
    CL_STORE
  } iclass_e;

  // Static per-opcode control fields, produced by the opcode decoder.
  typedef struct packed {
    logic       legal;
    iclass_e    iclass;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_dst;
  } dec_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory signal bundle.
// Latency: n/a (wires only).
// Backpressure: memory stalls the controller through mem_ready.
interface multicycle_control_if #(
  parameter int OPCODE_W = 6
);

  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                pc_write;
  logic                ir_write;
  logic                i_or_d;
  logic                reg_dst;
  logic                reg_write;
  logic [1:0]          alu_op;
  logic                alu_src;
  logic                mem_r;
  logic                mem_w;
  logic                mem_to_reg;
  logic                instr_done;
  logic                illegal_op;
  logic                bus_error;
  logic [2:0]          state;

  // Controller side
  modport master (
    input  opcode, mem_ready,
    output pc_write, ir_write, i_or_d, reg_dst, reg_write, alu_op, alu_src,
           mem_r, mem_w, mem_to_reg, instr_done, illegal_op, bus_error, state
  );

  // Datapath / memory side
  modport slave (
    output opcode, mem_ready,
    input  pc_write, ir_write, i_or_d, reg_dst, reg_write, alu_op, alu_src,
           mem_r, mem_w, mem_to_reg, instr_done, illegal_op, bus_error, state
  );

endinterface

// File: rtl/mc_opcode_decode.sv
// Maps an opcode to legality, instruction class and static ALU/register-select fields.
// Latency: combinational, zero cycles.
// Backpressure: none.
module mc_opcode_decode
  import mc_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] i_op,
  output dec_t                o_dec
);

  logic       w_hi_zero;
  logic [5:0] w_op6;

  // Opcodes wider than 6 bits are legal only when the extra bits are zero.
  assign w_hi_zero = ((i_op >> 6) == '0);
  assign w_op6     = i_op[5:0];

  // Opcode table; anything not listed decodes as illegal with inert fields.
  always_comb begin
    o_dec         = '0;
    o_dec.iclass  = CL_RTYPE;
    if (w_hi_zero) begin
      case (w_op6)
        OP_RTYPE: begin
          o_dec.legal   = 1'b1;
          o_dec.iclass  = CL_RTYPE;
          o_dec.alu_op  = ALU_FUNCT;
          o_dec.alu_src = 1'b0;
          o_dec.reg_dst = 1'b1;
        end
        OP_SUBIU: begin
          o_dec.legal   = 1'b1;
          o_dec.iclass  = CL_IMM_ALU;
          o_dec.alu_op  = ALU_SUB;
          o_dec.alu_src = 1'b1;
        end
        OP_SW: begin
          o_dec.legal   = 1'b1;
          o_dec.iclass  = CL_STORE;
          o_dec.alu_op  = ALU_ADD;
          o_dec.alu_src = 1'b1;
        end
        OP_LW: begin
          o_dec.legal   = 1'b1;
          o_dec.iclass  = CL_LOAD;
          o_dec.alu_op  = ALU_ADD;
          o_dec.alu_src = 1'b1;
        end
        OP_SLTI: begin
          o_dec.legal   = 1'b1;
          o_dec.iclass  = CL_IMM_ALU;
          o_dec.alu_op  = ALU_SLT;
          o_dec.alu_src = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with memory-timeout trap.
// Latency: 4 cycles ALU/store, 5 cycles load from FETCH entry to instr_done at zero wait.
// Backpressure: holds FETCH/MEM while mem_ready=0; MAX_WAIT+1 stalled cycles -> sticky ERROR.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = $clog2(MAX_WAIT + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master bus
);

  localparam logic [WAIT_W-1:0] LP_MAX = WAIT_W'(MAX_WAIT);

  state_e              r_state;
  state_e              w_nxt;
  logic [OPCODE_W-1:0] r_op_q;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic                r_bus_error;

  logic [OPCODE_W-1:0] w_dec_in;
  dec_t                w_dec;
  logic                w_in_wait;
  logic                w_timeout;

  logic                w_pc_write;
  logic                w_ir_write;
  logic                w_i_or_d;
  logic                w_reg_dst;
  logic                w_reg_write;
  logic [1:0]          w_alu_op;
  logic                w_alu_src;
  logic                w_mem_r;
  logic                w_mem_w;
  logic                w_mem_to_reg;
  logic                w_instr_done;
  logic                w_illegal_op;

  // In DECODE the opcode is not yet in op_q, so legality is judged on the live input.
  assign w_dec_in = (r_state == ST_DECODE) ? bus.opcode : r_op_q;

  mc_opcode_decode #(
    .OPCODE_W (OPCODE_W)
  ) u_dec (
    .i_op  (w_dec_in),
    .o_dec (w_dec)
  );

  assign w_in_wait = (r_state == ST_FETCH) || (r_state == ST_MEM);
  // A ready in the saturating cycle is a completion, not a timeout.
  assign w_timeout = w_in_wait && !bus.mem_ready && (r_wait_cnt == LP_MAX);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_BOOT;
    else        r_state <= w_nxt;
  end

  // Capture the opcode during DECODE for use by later phases
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     r_op_q <= '0;
    else if (r_state == ST_DECODE)  r_op_q <= bus.opcode;
  end

  // Consecutive not-ready counter; zero outside FETCH/MEM so every entry starts clean
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (w_in_wait && !bus.mem_ready) begin
      if (r_wait_cnt != LP_MAX) r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // Sticky bus error, set on the transition into ERROR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_bus_error <= 1'b0;
    else if (w_nxt == ST_ERROR)  r_bus_error <= 1'b1;
  end

  // Next-state and control strobes
  always_comb begin
    w_nxt        = r_state;
    w_pc_write   = 1'b0;
    w_ir_write   = 1'b0;
    w_i_or_d     = 1'b0;
    w_reg_dst    = 1'b0;
    w_reg_write  = 1'b0;
    w_alu_op     = ALU_ADD;
    w_alu_src    = 1'b0;
    w_mem_r      = 1'b0;
    w_mem_w      = 1'b0;
    w_mem_to_reg = 1'b0;
    w_instr_done = 1'b0;
    w_illegal_op = 1'b0;

    case (r_state)
      ST_BOOT: begin
        w_nxt = ST_FETCH;
      end

      ST_FETCH: begin
        w_mem_r = 1'b1;
        if (bus.mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_nxt      = ST_DECODE;
        end else if (w_timeout) begin
          w_nxt = ST_ERROR;
        end
      end

      ST_DECODE: begin
        if (w_dec.legal) begin
          w_nxt = ST_EXEC;
        end else begin
          w_illegal_op = 1'b1;
          w_nxt        = ST_FETCH;
        end
      end

      ST_EXEC: begin
        w_alu_src = w_dec.alu_src;
        w_alu_op  = w_dec.alu_op;
        if ((w_dec.iclass == CL_LOAD) || (w_dec.iclass == CL_STORE)) w_nxt = ST_MEM;
        else                                                         w_nxt = ST_WB;
      end

      ST_MEM: begin
        w_i_or_d  = 1'b1;
        w_alu_src = 1'b1;
        w_alu_op  = w_dec.alu_op;
        w_mem_r   = (w_dec.iclass == CL_LOAD);
        w_mem_w   = (w_dec.iclass == CL_STORE);
        if (bus.mem_ready) begin
          if (w_dec.iclass == CL_STORE) begin
            w_instr_done = 1'b1;
            w_nxt        = ST_FETCH;
          end else begin
            w_nxt = ST_WB;
          end
        end else if (w_timeout) begin
          w_nxt = ST_ERROR;
        end
      end

      ST_WB: begin
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_reg_dst    = w_dec.reg_dst;
        w_mem_to_reg = (w_dec.iclass == CL_LOAD);
        w_nxt        = ST_FETCH;
      end

      ST_ERROR: begin
        w_nxt = ST_ERROR;
      end

      default: begin
        w_nxt = ST_BOOT;
      end
    endcase
  end

  assign bus.pc_write   = w_pc_write;
  assign bus.ir_write   = w_ir_write;
  assign bus.i_or_d     = w_i_or_d;
  assign bus.reg_dst    = w_reg_dst;
  assign bus.reg_write  = w_reg_write;
  assign bus.alu_op     = w_alu_op;
  assign bus.alu_src    = w_alu_src;
  assign bus.mem_r      = w_mem_r;
  assign bus.mem_w      = w_mem_w;
  assign bus.mem_to_reg = w_mem_to_reg;
  assign bus.instr_done = w_instr_done;
  assign bus.illegal_op = w_illegal_op;
  assign bus.bus_error  = r_bus_error;
  assign bus.state      = r_state;

endmodule
